// File: rtl/pixel_line_pkg.sv
// rtl/pixel_line_pkg.sv - shared sizes and state encodings for the scanline buffer
package pixel_line_pkg;

  localparam int PIXEL_BITS_DEF      = 4;
  localparam int PIXELS_PER_WORD_DEF = 16;
  localparam int LINE_PIXELS_DEF     = 1280;
  localparam int WORD_BITS           = PIXEL_BITS_DEF * PIXELS_PER_WORD_DEF;
  localparam int WORDS               = LINE_PIXELS_DEF / PIXELS_PER_WORD_DEF;

  typedef enum logic {
    WR_FILLING,
    WR_FULL
  } wr_state_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_PREFETCH,
    RD_ACTIVE
  } rd_state_t;

endpackage

// File: rtl/pixel_line_bank.sv
// rtl/pixel_line_bank.sv - simple dual-port synchronous RAM, 1-cycle read latency
module pixel_line_bank
  import pixel_line_pkg::*;
#(
  parameter int DEPTH = 2 * WORDS,
  parameter int WIDTH = WORD_BITS,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/pixel_line_buffer.sv
// rtl/pixel_line_buffer.sv - ping-pong scanline buffer with underrun flag and x2 zoom
module pixel_line_buffer
  import pixel_line_pkg::*;
#(
  parameter int PIXEL_BITS      = PIXEL_BITS_DEF,
  parameter int PIXELS_PER_WORD = PIXELS_PER_WORD_DEF,
  parameter int LINE_PIXELS     = LINE_PIXELS_DEF
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  wr_valid,
  input  logic [PIXEL_BITS*PIXELS_PER_WORD-1:0] wr_data,
  output logic                                  wr_ready,
  input  logic                                  line_start,
  input  logic                                  zoom2,
  input  logic                                  pix_en,
  output logic [PIXEL_BITS-1:0]                 pix_out,
  output logic                                  pix_valid,
  output logic                                  line_done,
  output logic                                  underrun
);

  localparam int WBITS  = PIXEL_BITS * PIXELS_PER_WORD;
  localparam int NWORDS = LINE_PIXELS / PIXELS_PER_WORD;
  localparam int PW     = $clog2(NWORDS);
  localparam int RW     = $clog2(NWORDS + 1);
  localparam int AW     = $clog2(2 * NWORDS);
  localparam int XW     = $clog2(LINE_PIXELS + 1);
  localparam int IW     = $clog2(PIXELS_PER_WORD);

  // Both banks share one RAM: bank 1 occupies the upper NWORDS entries.
  function automatic logic [AW-1:0] bank_addr(input logic b, input logic [RW-1:0] w);
    return b ? AW'(NWORDS) + AW'(w) : AW'(w);
  endfunction

  wr_state_t         wr_state;
  logic [PW-1:0]     wptr;
  logic              front;
  logic              wr_acc;
  logic              last_word;
  logic              full_now;
  logic              swap;
  logic              front_nx;

  rd_state_t         rd_state;
  logic              pf_cnt;
  logic              pf_load;
  logic [WBITS-1:0]  sh;
  logic [WBITS-1:0]  pf;
  logic [IW-1:0]     pidx;
  logic [RW-1:0]     rword;
  logic [XW-1:0]     xcnt;
  logic              zoom;
  logic              phase;
  logic              blank;

  logic              advance;
  logic              word_end;
  logic              rd_issue;
  logic              rd_en;
  logic              rd_bank;
  logic [RW-1:0]     rd_word;
  logic [WBITS-1:0]  rdata;

  assign wr_acc    = wr_valid && wr_ready;
  assign last_word = wr_acc && (wptr == PW'(NWORDS - 1));
  assign full_now  = (wr_state == WR_FULL) || last_word;
  assign swap      = line_start && full_now;
  assign front_nx  = swap ? ~front : front;

  assign advance   = !zoom || phase;
  assign word_end  = (pidx == IW'(PIXELS_PER_WORD - 1));
  assign rd_issue  = (rd_state == RD_ACTIVE) && pix_en && !line_start && advance &&
                     word_end && (rword < RW'(NWORDS));

  // Word 0 is fetched in the line_start cycle itself, from the bank that
  // becomes front at the following edge.
  always_comb begin
    rd_en   = 1'b0;
    rd_bank = front;
    rd_word = '0;
    if (line_start) begin
      rd_en   = 1'b1;
      rd_bank = front_nx;
    end else if (rd_state == RD_PREFETCH && !pf_cnt) begin
      rd_en   = 1'b1;
      rd_word = RW'(1);
    end else if (rd_issue) begin
      rd_en   = 1'b1;
      rd_word = rword;
    end
  end

  pixel_line_bank #(
    .DEPTH(2 * NWORDS),
    .WIDTH(WBITS)
  ) u_bank (
    .clk  (clk),
    .we   (wr_acc),
    .waddr(bank_addr(~front, RW'(wptr))),
    .wdata(wr_data),
    .re   (rd_en),
    .raddr(bank_addr(rd_bank, rd_word)),
    .rdata(rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_state <= WR_FILLING;
      wptr     <= '0;
      wr_ready <= 1'b1;
      front    <= 1'b0;
    end else if (swap) begin
      front    <= ~front;
      wr_state <= WR_FILLING;
      wptr     <= '0;
      wr_ready <= 1'b1;
    end else if (wr_acc) begin
      wptr <= wptr + 1'b1;
      if (last_word) begin
        wr_state <= WR_FULL;
        wr_ready <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_state  <= RD_IDLE;
      pf_cnt    <= 1'b0;
      pf_load   <= 1'b0;
      sh        <= '0;
      pf        <= '0;
      pidx      <= '0;
      rword     <= '0;
      xcnt      <= '0;
      zoom      <= 1'b0;
      phase     <= 1'b0;
      blank     <= 1'b0;
      pix_out   <= '0;
      pix_valid <= 1'b0;
      line_done <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      pix_valid <= 1'b0;
      line_done <= 1'b0;
      pf_load   <= 1'b0;
      if (pf_load) begin
        pf <= rdata;
      end
      if (line_start) begin
        rd_state <= RD_PREFETCH;
        pf_cnt   <= 1'b0;
        zoom     <= zoom2;
        phase    <= 1'b0;
        blank    <= !full_now;
        pidx     <= '0;
        rword    <= RW'(2);
        xcnt     <= '0;
        if (!full_now) begin
          underrun <= 1'b1;
        end
      end else begin
        case (rd_state)
          RD_PREFETCH: begin
            if (!pf_cnt) begin
              sh     <= rdata;
              pf_cnt <= 1'b1;
            end else begin
              pf       <= rdata;
              rd_state <= RD_ACTIVE;
            end
          end
          RD_ACTIVE: begin
            if (pix_en) begin
              pix_valid <= 1'b1;
              pix_out   <= blank ? '0 : sh[PIXEL_BITS-1:0];
              xcnt      <= xcnt + 1'b1;
              if (zoom) begin
                phase <= ~phase;
              end
              if (advance) begin
                if (word_end) begin
                  sh   <= pf;
                  pidx <= '0;
                  if (rd_issue) begin
                    rword   <= rword + 1'b1;
                    pf_load <= 1'b1;
                  end
                end else begin
                  sh   <= sh >> PIXEL_BITS;
                  pidx <= pidx + 1'b1;
                end
              end
              if (xcnt == XW'(LINE_PIXELS - 1)) begin
                line_done <= 1'b1;
                rd_state  <= RD_IDLE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pixel_line_buffer.sv
// tb/tb_pixel_line_buffer.sv - randomized bench against a bank/line reference model
module tb_pixel_line_buffer;

  localparam int PB  = 4;
  localparam int PPW = 16;
  localparam int LP  = 1280;
  localparam int NW  = LP / PPW;
  localparam int WB  = PB * PPW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_valid = 1'b0;
  logic [WB-1:0] wr_data = '0;
  logic          wr_ready;
  logic          line_start = 1'b0;
  logic          zoom2 = 1'b0;
  logic          pix_en = 1'b0;
  logic [PB-1:0] pix_out;
  logic          pix_valid;
  logic          line_done;
  logic          underrun;

  always #5 clk = ~clk;

  pixel_line_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .line_start(line_start),
    .zoom2     (zoom2),
    .pix_en    (pix_en),
    .pix_out   (pix_out),
    .pix_valid (pix_valid),
    .line_done (line_done),
    .underrun  (underrun)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [WB-1:0] bank_m [2][NW];
  int front_m = 0;
  int back_cnt = 0;
  bit und_m = 1'b0;
  int exp_line [LP];
  bit line_act = 1'b0;
  int line_idx = 0;
  bit ev_valid;
  bit ev_done;
  int ev_pix;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WB-1:0] pat(input int n);
    logic [WB-1:0] w;
    for (int k = 0; k < PPW; k++) w[k*PB +: PB] = n[3:0];
    return w;
  endfunction

  function automatic logic [WB-1:0] rnd();
    return {$urandom, $urandom};
  endfunction

  task automatic start_line(input bit z);
    bit blank;
    int p;
    logic [WB-1:0] w;
    blank = (back_cnt != NW);
    if (!blank) begin
      front_m  = 1 - front_m;
      back_cnt = 0;
    end else begin
      und_m = 1'b1;
    end
    for (int s = 0; s < LP; s++) begin
      p = z ? s / 2 : s;
      w = bank_m[front_m][p / PPW];
      exp_line[s] = blank ? 0 : int'((w >> ((p % PPW) * PB)) & 64'hF);
    end
    line_act = 1'b1;
    line_idx = 0;
  endtask

  task automatic step(input bit v, input logic [WB-1:0] d, input bit ls, input bit z, input bit pe);
    check_val("wr_ready", wr_ready, back_cnt < NW);
    wr_valid = v; wr_data = d; line_start = ls; zoom2 = z; pix_en = pe;
    if (v && back_cnt < NW) begin
      bank_m[1 - front_m][back_cnt] = d;
      back_cnt++;
    end
    ev_valid = 1'b0;
    ev_done  = 1'b0;
    if (ls) begin
      start_line(z);
    end else if (pe && line_act) begin
      ev_valid = 1'b1;
      ev_pix   = exp_line[line_idx];
      ev_done  = (line_idx == LP - 1);
      line_idx++;
      if (line_idx == LP) line_act = 1'b0;
    end
    @(posedge clk);
    #1;
    check_val("pix_valid", pix_valid, ev_valid);
    check_val("line_done", line_done, ev_done);
    check_val("underrun", underrun, und_m);
    if (ev_valid) check_val($sformatf("pix_out[%0d]", line_idx - 1), pix_out, ev_pix);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wr_valid = 1'b0; line_start = 1'b0; pix_en = 1'b0; zoom2 = 1'b0; wr_data = '0;
    @(posedge clk);
    #1;
    front_m = 0; back_cnt = 0; und_m = 1'b0; line_act = 1'b0;
    check_val("rst_pix_out", pix_out, 0);
    check_val("rst_pix_valid", pix_valid, 0);
    check_val("rst_line_done", line_done, 0);
    check_val("rst_underrun", underrun, 0);
    check_val("rst_wr_ready", wr_ready, 1);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic full_line();
    for (int i = 0; i < LP; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    bit z;
    @(negedge clk);
    do_reset();

    // Counting pattern, one pixel per cycle
    for (int n = 0; n < NW; n++) step(1'b1, pat(n), 1'b0, 1'b0, 1'b0);
    idle(1);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle(2);
    full_line();
    idle(3);

    // Underrun with 79 words, then recovery with the 80th
    for (int n = 0; n < NW - 1; n++) step(1'b1, rnd(), 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle(2);
    full_line();
    step(1'b1, rnd(), 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle(2);
    full_line();
    idle(2);

    // Zoom x2 with a ramp in word 0
    step(1'b1, 64'hFEDCBA9876543210, 1'b0, 1'b0, 1'b0);
    for (int n = 1; n < NW; n++) step(1'b1, rnd(), 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    idle(2);
    full_line();
    idle(2);

    // Final word together with line_start, abort at pixel 500, slow pixel rate
    for (int n = 0; n < NW - 1; n++) step(1'b1, rnd(), 1'b0, 1'b0, 1'b0);
    step(1'b1, rnd(), 1'b1, 1'b0, 1'b0);
    step(1'b1, rnd(), 1'b0, 1'b0, 1'b0);
    step(1'b1, rnd(), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 500; i++) step(1'b1, rnd(), 1'b0, 1'b0, 1'b1);
    step(1'b1, rnd(), 1'b1, 1'b0, 1'b0);
    step(1'b1, rnd(), 1'b0, 1'b0, 1'b0);
    step(1'b1, rnd(), 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 3 * LP + 10 && line_act; c++)
      step(1'b1, rnd(), 1'b0, 1'b0, (c % 3) == 0);
    idle(2);

    // Random rates and zoom
    z = 1'($urandom_range(0, 1));
    step(1'b0, '0, 1'b1, z, 1'b0);
    for (int c = 0; c < 6 * LP && line_act; c++)
      step(1'($urandom_range(0, 1)), rnd(), 1'b0, z, c >= 2 && 1'($urandom_range(0, 1)));
    idle(2);

    // Reset in the middle of a line
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle(2);
    for (int i = 0; i < 100; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    do_reset();
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
